// File: rtl/ws2812_multi.sv
// WS2812-family LED driver: one shared bit-timing engine serialises a wide pixel
// word per LED index onto STRIPS parallel lines, then holds them low to latch.
module ws2812_multi #(
  parameter int STRIPS         = 4,
  parameter int LED_COUNT      = 64,
  parameter int BITS_PER_PIXEL = 24,
  parameter int CYCLES_0_HIGH  = 21,
  parameter int CYCLES_1_HIGH  = 42,
  parameter int CYCLES_BIT     = 63,
  parameter int CYCLES_RESET   = 2600,
  parameter int REVERSE        = 0,
  parameter int FREE_RUN       = 0,
  parameter int ADDR_W         = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               start_i,
  output logic                               busy_o,
  output logic                               frame_done_o,
  output logic [ADDR_W-1:0]                  address_o,
  input  logic [STRIPS*BITS_PER_PIXEL-1:0]   pixel_i,
  output logic [STRIPS-1:0]                  data_o
);

  localparam int CNT_MAX = (CYCLES_BIT > CYCLES_RESET) ? CYCLES_BIT : CYCLES_RESET;
  localparam int PHASE_W = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;

  localparam logic [PHASE_W-1:0] PH_ONE      = PHASE_W'(1);
  localparam logic [PHASE_W-1:0] PH_C0       = PHASE_W'(CYCLES_0_HIGH);
  localparam logic [PHASE_W-1:0] PH_C1       = PHASE_W'(CYCLES_1_HIGH);
  localparam logic [PHASE_W-1:0] PH_BIT_LAST = PHASE_W'(CYCLES_BIT - 1);
  localparam logic [PHASE_W-1:0] PH_RST_LAST = PHASE_W'(CYCLES_RESET - 1);
  localparam logic [BIT_W-1:0]   BIT_ONE     = BIT_W'(1);
  localparam logic [BIT_W-1:0]   BIT_LAST    = BIT_W'(BITS_PER_PIXEL - 1);
  localparam logic [ADDR_W-1:0]  P_ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  P_LAST      = ADDR_W'(LED_COUNT - 1);
  localparam logic [ADDR_W:0]    NEXT_ONE    = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_e;

  state_e                                  state_q, state_d;
  logic [PHASE_W-1:0]                      phase_q, phase_d;
  logic [BIT_W-1:0]                        bit_q, bit_d;
  logic [ADDR_W-1:0]                       p_q, p_d;
  logic [STRIPS-1:0][BITS_PER_PIXEL-1:0]   shift_q, shift_d;
  logic                                    pending_q, pending_d;
  logic [STRIPS-1:0]                       data_q, data_d;
  logic                                    busy_q, busy_d;
  logic                                    done_q, done_d;
  logic [ADDR_W-1:0]                       addr_q, addr_d;

  // Pixel index to RAM address; index LED_COUNT is only ever a don't-care prefetch.
  function automatic logic [ADDR_W-1:0] addrOf(input logic [ADDR_W:0] idx);
    if (REVERSE != 0) begin
      return ADDR_W'(LED_COUNT - 1 - int'(idx));
    end
    return idx[ADDR_W-1:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    p_d       = p_q;
    shift_d   = shift_q;
    data_d    = '0;
    pending_d = pending_q || (start_i && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start_i || (FREE_RUN != 0)) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = pixel_i;
        p_d     = '0;
        bit_d   = '0;
        phase_d = '0;
        state_d = SEND;
      end
      SEND: begin
        for (int k = 0; k < STRIPS; k++) begin
          data_d[k] = (phase_q < (shift_q[k][BITS_PER_PIXEL-1] ? PH_C1 : PH_C0));
        end
        if (phase_q == PH_BIT_LAST) begin
          phase_d = '0;
          if (bit_q != BIT_LAST) begin
            for (int k = 0; k < STRIPS; k++) begin
              shift_d[k] = shift_q[k] << 1;
            end
            bit_d = bit_q + BIT_ONE;
          end else if (p_q != P_LAST) begin
            // The next pixel was prefetched while this one was being sent.
            shift_d = pixel_i;
            p_d     = p_q + P_ONE;
            bit_d   = '0;
          end else begin
            state_d = LATCH;
          end
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      LATCH: begin
        if (phase_q == PH_RST_LAST) begin
          phase_d = '0;
          state_d = (pending_q || start_i || (FREE_RUN != 0)) ? LOAD : IDLE;
        end else begin
          phase_d = phase_q + PH_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == LOAD) begin
      pending_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == LATCH) && (phase_d == PH_RST_LAST);
    addr_d = (state_d == SEND) ? addrOf({1'b0, p_d} + NEXT_ONE) : addrOf('0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      bit_q     <= '0;
      p_q       <= '0;
      shift_q   <= '0;
      pending_q <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= addrOf('0);
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      p_q       <= p_d;
      shift_q   <= shift_d;
      pending_q <= pending_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
    end
  end

  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign address_o    = addr_q;
  assign data_o       = data_q;

endmodule
